// File: rtl/wb_mac_accel_pkg.sv
// Shared definitions for the Wishbone multiply-accumulate accelerator:
// register map, CTRL layout/defaults and the sequencer state encoding.
package wb_mac_accel_pkg;

    localparam logic [2:0] REG_ADDR   = 3'd0;
    localparam logic [2:0] REG_START  = 3'd1;
    localparam logic [2:0] REG_ACC    = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam int CTRL_TAPS_LSB = 0;
    localparam int CTRL_CSTR_LSB = 8;
    localparam int CTRL_DSTR_LSB = 16;
    localparam int CTRL_CH_LSB   = 28;
    localparam int CTRL_SAT_BIT  = 30;

    localparam logic [7:0]  TAPS_RST = 8'd8;
    localparam logic [7:0]  CSTR_RST = 8'd64;
    localparam logic [11:0] DSTR_RST = 12'd128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic        sat;
        logic [1:0]  ch;
        logic [11:0] dstride;
        logic [7:0]  cstride;
        logic [7:0]  taps;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{
        sat:     1'b0,
        ch:      2'd0,
        dstride: DSTR_RST,
        cstride: CSTR_RST,
        taps:    TAPS_RST
    };

    function automatic ctrl_t ctrl_unpack(input logic [31:0] d);
        ctrl_t c;
        c.taps    = d[CTRL_TAPS_LSB +: 8];
        c.cstride = d[CTRL_CSTR_LSB +: 8];
        c.dstride = d[CTRL_DSTR_LSB +: 12];
        c.ch      = d[CTRL_CH_LSB +: 2];
        c.sat     = d[CTRL_SAT_BIT];
        return c;
    endfunction

    function automatic logic [31:0] ctrl_pack(input ctrl_t c);
        logic [31:0] d;
        d = '0;
        d[CTRL_TAPS_LSB +: 8]  = c.taps;
        d[CTRL_CSTR_LSB +: 8]  = c.cstride;
        d[CTRL_DSTR_LSB +: 12] = c.dstride;
        d[CTRL_CH_LSB +: 2]    = c.ch;
        d[CTRL_SAT_BIT]        = c.sat;
        return d;
    endfunction

endpackage

// File: rtl/wb_mac_accel_mac.sv
// Product register followed by a full-precision add into the selected
// accumulator, with modulo wrap or two's-complement saturation.
module mac_sat_stage #(
    parameter int COEF_W = 18,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [31:0]       data,
    input  logic signed [COEF_W-1:0] coef,
    input  logic                     sat,
    input  logic [ACC_W-1:0]         acc_in,
    output logic                     sum_valid,
    output logic [ACC_W-1:0]         sum
);
    localparam int PW = COEF_W + 32;
    localparam int SW = (PW > ACC_W ? PW : ACC_W) + 1;

    logic signed [PW-1:0] prod_q;
    logic                 prod_v_q;
    logic signed [SW-1:0] full;
    logic signed [SW-1:0] hi;
    logic signed [SW-1:0] lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q   <= '0;
            prod_v_q <= 1'b0;
        end else begin
            prod_v_q <= in_valid;
            if (in_valid)
                prod_q <= PW'(data) * PW'(coef);
        end
    end

    // One guard bit above the wider operand makes the sum exact.
    assign full = SW'($signed(acc_in)) + SW'(prod_q);
    assign hi   = SW'($signed({1'b0, {(ACC_W-1){1'b1}}}));
    assign lo   = SW'($signed({1'b1, {(ACC_W-1){1'b0}}}));

    always_comb begin
        sum = full[ACC_W-1:0];
        if (sat) begin
            if (full > hi)
                sum = hi[ACC_W-1:0];
            else if (full < lo)
                sum = lo[ACC_W-1:0];
        end
    end

    assign sum_valid = prod_v_q;

endmodule

// File: rtl/wb_mac_accel.sv
// Wishbone-controlled strided dot-product engine: streams samples and
// coefficients, multiplies them and accumulates into one of NUM_CH registers.
module wb_mac_accel #(
    parameter int COEF_W = 18,
    parameter int ACC_W  = 32,
    parameter int MEM_AW = 19,
    parameter int IDX_W  = 9,
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [2:0]        wb_adr,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_rd_adr,
    input  logic [31:0]       mem_rd_data,
    output logic [IDX_W-1:0]  coef_idx,
    input  logic [COEF_W-1:0] coef_data,
    output logic              busy
);
    import wb_mac_accel_pkg::*;

    localparam int XW = ACC_W > 32 ? ACC_W : 32;

    function automatic logic [31:0] acc_to_32(
        input logic [ACC_W-1:0] a
    );
        logic [XW-1:0] t;
        t = XW'($signed(a));
        return t[31:0];
    endfunction

    function automatic logic [ACC_W-1:0] acc_from_32(
        input logic [31:0] d
    );
        logic [XW-1:0] t;
        t = XW'($signed(d));
        return t[ACC_W-1:0];
    endfunction

    state_t            state_q;
    state_t            state_d;
    ctrl_t             ctrl_q;
    logic [31:0]       addr_q;
    logic [7:0]        taps_q;
    logic [7:0]        cnt_q;
    logic [7:0]        cstr_q;
    logic [11:0]       dstr_q;
    logic [1:0]        ch_q;
    logic              sat_q;
    logic              v1_q;
    logic              rd_ack_q;
    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_wb;
    logic [ACC_W-1:0]  acc_mac;
    logic [ACC_W-1:0]  sum;
    logic              sum_valid;
    logic [31:0]       rd_mux;
    logic              req;
    logic              stall;
    logic              wr_ack;
    logic              rd_fire;
    logic              start_go;
    logic              last_issue;

    // Only a STATUS read may complete while an operation runs.
    assign req      = wb_cyc & wb_stb;
    assign stall    = busy & ~(~wb_we & (wb_adr == REG_STATUS));
    assign wr_ack   = req & wb_we & ~stall & ~reset;
    assign rd_fire  = req & ~wb_we & ~stall & ~rd_ack_q;
    assign wb_ack   = wr_ack | rd_ack_q;
    assign start_go = wr_ack & (wb_adr == REG_START)
                    & (ctrl_q.taps != 8'd0);
    assign last_issue = cnt_q == taps_q - 8'd1;

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_go) state_d = ST_ISSUE;
            ST_ISSUE: if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (cnt_q == 8'd1) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        mem_rd_en = 1'b0;
        unique case (state_q)
            ST_ISSUE: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
            end
            ST_DRAIN: busy = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            taps_q     <= '0;
            cnt_q      <= '0;
            cstr_q     <= '0;
            dstr_q     <= '0;
            ch_q       <= '0;
            sat_q      <= 1'b0;
            v1_q       <= 1'b0;
            mem_rd_adr <= '0;
            coef_idx   <= '0;
        end else begin
            v1_q <= mem_rd_en;
            if (start_go) begin
                taps_q     <= ctrl_q.taps;
                cstr_q     <= ctrl_q.cstride;
                dstr_q     <= ctrl_q.dstride;
                ch_q       <= ctrl_q.ch;
                sat_q      <= ctrl_q.sat;
                cnt_q      <= '0;
                mem_rd_adr <= addr_q[MEM_AW+1:2];
                coef_idx   <= wb_dat_i[IDX_W-1:0];
            end else if (state_q == ST_ISSUE) begin
                cnt_q <= last_issue ? 8'd0 : cnt_q + 8'd1;
                // Addresses stop on the last tap so they hold afterwards.
                if (!last_issue) begin
                    mem_rd_adr <= mem_rd_adr + MEM_AW'(dstr_q);
                    coef_idx   <= coef_idx + IDX_W'(cstr_q);
                end
            end else if (state_q == ST_DRAIN) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    mac_sat_stage #(
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (v1_q),
        .data      (mem_rd_data),
        .coef      (coef_data),
        .sat       (sat_q),
        .acc_in    (acc_mac),
        .sum_valid (sum_valid),
        .sum       (sum)
    );

    always_comb begin
        acc_wb  = '0;
        acc_mac = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ctrl_q.ch == 2'(c))
                acc_wb = acc_q[c];
            if (ch_q == 2'(c))
                acc_mac = acc_q[c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++)
                acc_q[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (sum_valid && ch_q == 2'(c))
                    acc_q[c] <= sum;
                else if (wr_ack && wb_adr == REG_ACC
                         && ctrl_q.ch == 2'(c))
                    acc_q[c] <= acc_from_32(wb_dat_i);
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            wb_adr == REG_ADDR:   rd_mux = addr_q;
            wb_adr == REG_ACC:    rd_mux = acc_to_32(acc_wb);
            wb_adr == REG_CTRL:   rd_mux = ctrl_pack(ctrl_q);
            wb_adr == REG_STATUS: rd_mux = {31'd0, busy};
            default:              rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            ctrl_q   <= CTRL_RST;
            rd_ack_q <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            rd_ack_q <= rd_fire;
            if (rd_fire)
                wb_dat_o <= rd_mux;
            if (wr_ack && wb_adr == REG_ADDR)
                addr_q <= wb_dat_i;
            if (wr_ack && wb_adr == REG_CTRL)
                ctrl_q <= ctrl_unpack(wb_dat_i);
        end
    end

endmodule

// File: tb/tb_wb_mac_accel.sv
// Directed bench: bus reads and memory issues are checked by scoreboard
// monitors against expectations queued when the stimulus is issued.
module tb_wb_mac_accel;
    localparam int COEF_W = 18;
    localparam int ACC_W  = 32;
    localparam int MEM_AW = 19;
    localparam int IDX_W  = 9;
    localparam int NUM_CH = 2;

    localparam logic [2:0] A_ADDR   = 3'd0;
    localparam logic [2:0] A_START  = 3'd1;
    localparam logic [2:0] A_ACC    = 3'd2;
    localparam logic [2:0] A_CTRL   = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wb_cyc = 1'b0;
    logic              wb_stb = 1'b0;
    logic              wb_we = 1'b0;
    logic [2:0]        wb_adr = '0;
    logic [31:0]       wb_dat_i = '0;
    logic [31:0]       wb_dat_o;
    logic              wb_ack;
    logic              mem_rd_en;
    logic [MEM_AW-1:0] mem_rd_adr;
    logic [31:0]       mem_rd_data = '0;
    logic [IDX_W-1:0]  coef_idx;
    logic [COEF_W-1:0] coef_data = '0;
    logic              busy;

    always #5 clk = ~clk;

    wb_mac_accel #(
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W),
        .MEM_AW (MEM_AW),
        .IDX_W  (IDX_W),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_cyc      (wb_cyc),
        .wb_stb      (wb_stb),
        .wb_we       (wb_we),
        .wb_adr      (wb_adr),
        .wb_dat_i    (wb_dat_i),
        .wb_dat_o    (wb_dat_o),
        .wb_ack      (wb_ack),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_adr  (mem_rd_adr),
        .mem_rd_data (mem_rd_data),
        .coef_idx    (coef_idx),
        .coef_data   (coef_data),
        .busy        (busy)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [MEM_AW-1:0] adr;
        logic [IDX_W-1:0]  idx;
    } iss_t;

    exp_t rd_q[$];
    iss_t iss_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic [31:0]       mem_m  [0:(1<<MEM_AW)-1];
    logic [COEF_W-1:0] coef_m [0:(1<<IDX_W)-1];

    always @(posedge clk) begin
        mem_rd_data <= mem_m[mem_rd_adr];
        coef_data   <= coef_m[coef_idx];
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h",
                     name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wb_ack && !wb_we) begin
            if (rd_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected read ack: data 0x%08h",
                         wb_dat_o);
            end else begin
                exp_t e;
                e = rd_q.pop_front();
                check(e.name, wb_dat_o, e.val);
            end
        end
    end

    always @(negedge clk) begin
        if (mem_rd_en) begin
            if (iss_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected read issue: adr 0x%05h idx %0d",
                         mem_rd_adr, coef_idx);
            end else begin
                iss_t s;
                s = iss_q.pop_front();
                check("issue mem_rd_adr", 32'(mem_rd_adr), 32'(s.adr));
                check("issue coef_idx", 32'(coef_idx), 32'(s.idx));
            end
        end
    end

    task automatic push_iss(input int adr, input int idx);
        iss_t s;
        s.adr = MEM_AW'(adr);
        s.idx = IDX_W'(idx);
        iss_q.push_back(s);
    endtask

    task automatic wb_write(input logic [2:0] a,
                            input logic [31:0] d,
                            output int lat);
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we = 1'b1;
        wb_adr = a;
        wb_dat_i = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!wb_ack && lat < 200);
        if (!wb_ack) begin
            n_chk++;
            n_fail++;
            $display("FAIL write ack timeout: adr %0d", a);
        end
        @(posedge clk);
        #1;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        int l;
        wb_write(a, d, l);
    endtask

    task automatic wb_read(input logic [2:0] a,
                           input string name,
                           input logic [31:0] exp,
                           output int lat,
                           output logic busy_at_ack);
        exp_t e;
        e.name = name;
        e.val = exp;
        rd_q.push_back(e);
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we = 1'b0;
        wb_adr = a;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!wb_ack && lat < 200);
        busy_at_ack = busy;
        if (!wb_ack) begin
            n_chk++;
            n_fail++;
            $display("FAIL read ack timeout: %s", name);
        end
        @(posedge clk);
        #1;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a,
                      input string name,
                      input logic [31:0] exp);
        int   l;
        logic b;
        wb_read(a, name, exp, l, b);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   n;
        logic b;
        logic seen;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset busy", 32'(busy), 0);
        check("reset wb_ack", 32'(wb_ack), 0);
        check("reset mem_rd_en", 32'(mem_rd_en), 0);
        check("reset wb_dat_o", wb_dat_o, 0);
        @(posedge clk);
        #1;
        rd(A_CTRL, "reset CTRL", 32'h0080_4008);
        rd(A_ADDR, "reset ADDR", 32'h0);
        rd(A_ACC, "reset ACC", 32'h0);

        // 8-tap dot product with default strides
        for (int k = 0; k < 8; k++) begin
            mem_m[32'h400 + 128 * k] = 32'(k + 1);
            coef_m[(5 + 64 * k) % 512] = 18'd2;
            push_iss(32'h400 + 128 * k, (5 + 64 * k) % 512);
        end
        wr(A_ADDR, 32'h0000_1000);
        wr(A_ACC, 32'h0);
        wb_write(A_START, 32'd5, lat);
        check("start ack latency", lat, 1);
        wait_idle(n);
        check("busy drop taps=8", n, 11);
        rd(A_ACC, "acc after 8 taps", 32'd72);

        // single tap, saturating then wrapping
        mem_m[32'h800] = 32'h7FFF_FFFF;
        coef_m[0] = 18'd2;
        wr(A_ADDR, 32'h0000_2000);
        wr(A_CTRL, 32'h4080_4001);
        wr(A_ACC, 32'h7FFF_FFF0);
        push_iss(32'h800, 0);
        wr(A_START, 32'd0);
        wait_idle(n);
        check("busy drop taps=1", n, 4);
        rd(A_ACC, "acc saturated", 32'h7FFF_FFFF);
        wr(A_CTRL, 32'h0080_4001);
        wr(A_ACC, 32'h7FFF_FFF0);
        push_iss(32'h800, 0);
        wr(A_START, 32'd0);
        wait_idle(n);
        rd(A_ACC, "acc wrapped", 32'h7FFF_FFEE);

        // coefficient index wraps past 511
        mem_m[0] = 32'd1;
        mem_m[128] = 32'd2;
        mem_m[256] = 32'd3;
        mem_m[384] = 32'd4;
        coef_m[500] = 18'h3FFFF;
        coef_m[52] = 18'd3;
        coef_m[116] = 18'd5;
        coef_m[180] = 18'd7;
        push_iss(0, 500);
        push_iss(128, 52);
        push_iss(256, 116);
        push_iss(384, 180);
        wr(A_ADDR, 32'h0);
        wr(A_CTRL, 32'h0080_4004);
        wr(A_ACC, 32'h0);
        wr(A_START, 32'd500);
        wait_idle(n);
        check("busy drop taps=4", n, 7);
        rd(A_ACC, "acc idx wrap", 32'd48);

        // channel 1 run with bus accesses during busy
        wr(A_ACC, 32'h0001_2345);
        wr(A_CTRL, 32'h1080_4004);
        wr(A_ACC, 32'd10);
        wr(A_ADDR, 32'h0000_3000);
        mem_m[32'hC00] = 32'd5;
        mem_m[32'hC80] = 32'hFFFF_FFFD;
        mem_m[32'hD00] = 32'd2;
        mem_m[32'hD80] = 32'd1;
        coef_m[7] = 18'd4;
        coef_m[71] = 18'd6;
        coef_m[135] = 18'd1;
        coef_m[199] = 18'd1;
        push_iss(32'hC00, 7);
        push_iss(32'hC80, 71);
        push_iss(32'hD00, 135);
        push_iss(32'hD80, 199);
        wr(A_START, 32'd7);
        wb_read(A_STATUS, "status during busy", 32'd1, lat, b);
        check("status read latency", lat, 2);
        wb_read(A_ACC, "acc ch1", 32'd15, lat, b);
        check("acc read busy at ack", 32'(b), 0);
        wr(A_CTRL, 32'h0080_4004);
        rd(A_ACC, "acc ch0 untouched", 32'h0001_2345);

        // reset during the fourth issue cycle
        wr(A_CTRL, 32'h0080_4008);
        wr(A_ADDR, 32'h0000_1000);
        for (int k = 0; k < 4; k++)
            push_iss(32'h400 + 128 * k, (5 + 64 * k) % 512);
        wr(A_START, 32'd5);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort busy", 32'(busy), 0);
        check("abort mem_rd_en", 32'(mem_rd_en), 0);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1;
        rd(A_ACC, "abort ACC", 32'h0);
        rd(A_CTRL, "abort CTRL", 32'h0080_4008);

        // taps=0 start is a no-op
        wr(A_CTRL, 32'h0080_4000);
        wr(A_ACC, 32'h0000_0055);
        wb_write(A_START, 32'd3, lat);
        check("taps0 ack latency", lat, 1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy || mem_rd_en)
                seen = 1'b1;
        end
        check("taps0 activity", 32'(seen), 0);
        @(posedge clk);
        #1;
        rd(A_ACC, "taps0 ACC", 32'h0000_0055);

        repeat (5) @(negedge clk);
        check("read scoreboard drained", rd_q.size(), 0);
        check("issue scoreboard drained", iss_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_mac_accel.md
WB_MAC_ACCEL -- requirements
Module: wb_mac_accel

Interface
REQ-001 SHALL have parameter COEF_W, default 18, signed coefficient width.
REQ-002 SHALL have parameter ACC_W, default 32, accumulator width.
REQ-003 SHALL have parameter MEM_AW, default 19, data-memory word-address width.
REQ-004 SHALL have parameter IDX_W, default 9, coefficient-index width.
REQ-005 SHALL have parameter NUM_CH, default 2, number of independent accumulators (1..4).
REQ-006 SHALL use one clock; reset is synchronous and active-high; clock port clk, reset port reset.
REQ-007 SHALL have ports, in this order:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- wb_cyc  in  1  Wishbone cycle.
- wb_stb  in  1  Wishbone strobe.
- wb_we  in  1  write enable.
- wb_adr  in  3  word offset of the register.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack  out  1  acknowledge.
- mem_rd_en  out  1  data-memory read strobe.
- mem_rd_adr  out  MEM_AW  data word address.
- mem_rd_data  in  32  signed sample; valid 1 cycle after mem_rd_en.
- coef_idx  out  IDX_W  coefficient ROM index.
- coef_data  in  COEF_W  signed coefficient; valid 1 cycle after coef_idx is driven.
- busy  out  1  an operation is in progress.

Function
REQ-008 SHALL decode the following registers by word offset:
- 0 ADDR: byte address; word address = ADDR[MEM_AW+1:2].
- 1 START: write loads the coefficient index and starts an operation.
- 2 ACC: accesses ACC[CTRL.ch]; a write loads it, a read returns it sign-extended or truncated to 32 bits.
- 3 CTRL: [7:0] taps, [15:8] coefficient stride, [27:16] data stride in words, [29:28] ch, [30] sat.
- 4 STATUS: [0] busy; read-only.
REQ-009 SHALL acknowledge writes in the same cycle as wb_cyc&wb_stb, and reads one cycle later from registered data, with wb_ack a single-cycle pulse per access.
REQ-010 SHALL stall wb_ack while busy for every access except a STATUS read.
REQ-011 SHALL implement FSM states IDLE, ISSUE and DRAIN.
- IDLE -> ISSUE on an acked START write with taps != 0.
- ISSUE -> DRAIN after issuing taps reads.
- DRAIN -> IDLE after 2 cycles.
REQ-012 SHALL, with taps=0, ack the START write, stay in IDLE and leave ACC unchanged.
REQ-013 SHALL, in ISSUE cycle k (k=0..taps-1), assert mem_rd_en and drive:
- mem_rd_adr = base + k*dstride, modulo 2^MEM_AW;
- coef_idx = index + k*cstride, modulo 2^IDX_W.
REQ-014 SHALL register the full-precision product (COEF_W+32 bits) one cycle after data is valid, and add it to ACC[ch] in the following cycle.
REQ-015 SHALL, with sat=0, keep the sum modulo 2^ACC_W; with sat=1, clamp it to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-016 SHALL keep busy high from the cycle after the START ack through the final accumulate; busy SHALL drop exactly taps+3 cycles after the ack.
REQ-017 SHALL latch ch and sat at start; a mid-operation CTRL write is impossible because REQ-010 stalls it.
REQ-018 SHALL keep mem_rd_en low in IDLE and DRAIN; mem_rd_adr and coef_idx hold their last value.

Reset
REQ-019 SHALL, on reset, set:
- state IDLE, busy 0, wb_ack 0, mem_rd_en 0, wb_dat_o 0;
- all ACC 0, ADDR 0, pipeline registers 0;
- CTRL = taps 8, cstride 64, dstride 128, ch 0, sat 0.
REQ-020 SHALL abort an in-flight operation on reset, discard pending products, and issue no further reads.

Structure
REQ-021 SHALL take register offsets, CTRL field positions, CTRL reset defaults and the state enum from package wb_mac_accel_pkg.
REQ-022 SHALL instantiate one sub-module, mac_sat_stage, containing the product register, the adder and the wrap/saturate logic.

Verification
REQ-023 SHALL verify: defaults, ADDR=0x1000, START=5, ACC=0, memory[0x400+128k]=k+1, coef[5+64k]=2 -> ACC reads 72 after 8 taps; busy lasts 11 cycles.
REQ-024 SHALL verify: sat=1, ACC=0x7FFFFFF0, one tap 0x7FFFFFFF*2 -> 0x7FFFFFFF; same with sat=0 -> 0x7FFFFFEE (modulo).
REQ-025 SHALL verify: START=500, cstride 64, taps 4 -> coef_idx sequence 500, 52, 116, 180 (index wrap).
REQ-026 SHALL verify: ch=1 operation -> ACC[0] unchanged; an ACC read during busy is acked only after busy falls, while a STATUS read during busy is acked in 2 cycles with value 1.
REQ-027 SHALL verify: reset asserted during ISSUE k=3 -> next cycle busy=0 and mem_rd_en=0, ACC reads 0, CTRL reads defaults.
REQ-028 SHALL verify: a START write with taps=0 -> acked in the same cycle, busy never rises, no mem_rd_en pulse.
